// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared controller opcodes, HLT sub-op, step state enum and step counter width
package ctrl_pkg;
  localparam int CNT_W = 3;
  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_LDRRI = 5'b00011;
  localparam logic [4:0] OP_HLT = 5'b11100;
  localparam logic [1:0] SUB_HLT = 2'b01;
  typedef enum logic {RUN, HALT} seq_state_t;
endpackage

// File: rtl/seq_watchdog.sv
// seq_watchdog: in RUN, a last step (cnt all-ones) without buff_pc forces cnt to 0 (force_zero) and sets sticky step_err until rst
module seq_watchdog #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt,
  input  logic             buff_pc,
  input  logic             run,
  output logic             force_zero,
  output logic             step_err
);
  assign force_zero = run && (&cnt) && !buff_pc;
  always_ff @(posedge clk)
    if (rst) step_err <= 1'b0;
    else if (force_zero) step_err <= 1'b1;
endmodule

// File: rtl/ins_step_sequencer.sv
// ins_step_sequencer: IR latch + step counter Cnt with RUN/HALT state; in clk,Rst,InsIn,Buff_PC; out Cnt,InsM,InsL,IR,Fetch,Halted,StepErr (watchdog under SEQ_WATCHDOG_EN)
module ins_step_sequencer
  import ctrl_pkg::*;
#(
  parameter int         CNT_W = ctrl_pkg::CNT_W,
  parameter logic [4:0] HLT_M = OP_HLT,
  parameter logic [1:0] HLT_L = SUB_HLT
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic [15:0]      InsIn,
  input  logic             Buff_PC,
  output logic [CNT_W-1:0] Cnt,
  output logic [4:0]       InsM,
  output logic [1:0]       InsL,
  output logic [15:0]      IR,
  output logic             Fetch,
  output logic             Halted,
  output logic             StepErr
);
  seq_state_t state;
  logic force_zero;
  logic hlt;
  assign InsM = IR[15:11];
  assign InsL = IR[1:0];
  assign Fetch = (state == RUN) && (Cnt == '0);
  assign hlt = (InsM == HLT_M) && (InsL == HLT_L) && Buff_PC;
`ifdef SEQ_WATCHDOG_EN
  seq_watchdog #(.CNT_W(CNT_W)) u_wd (
    .clk(clk),
    .rst(Rst),
    .cnt(Cnt),
    .buff_pc(Buff_PC),
    .run(state == RUN),
    .force_zero(force_zero),
    .step_err(StepErr)
  );
`else
  assign force_zero = 1'b0;
  assign StepErr = 1'b0;
`endif
  always_ff @(posedge clk)
    if (Rst) begin
      state <= RUN;
      Cnt <= '0;
      IR <= '0;
      Halted <= 1'b0;
    end else if (state == RUN) begin
      if (Cnt == '0) IR <= InsIn;
      if (hlt) begin
        state <= HALT;
        Halted <= 1'b1;
        Cnt <= '0;
      end else Cnt <= (Buff_PC || force_zero) ? '0 : Cnt + 1'b1;
    end
endmodule

// File: tb/tb_ins_step_sequencer.sv
// tb_ins_step_sequencer: table-driven directed check of ins_step_sequencer plus hand sequences for last-step wrap and HLT hold
module tb_ins_step_sequencer;
`ifdef SEQ_WATCHDOG_EN
  localparam logic WD = 1'b1;
`else
  localparam logic WD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] ins_in = 16'hFFFF;
  logic buff_pc = 1'b0;
  logic [2:0] cnt;
  logic [4:0] ins_m;
  logic [1:0] ins_l;
  logic [15:0] ir;
  logic fetch, halted, step_err;
  int tests = 0;
  int fails = 0;

  ins_step_sequencer dut (
    .clk(clk),
    .Rst(rst),
    .InsIn(ins_in),
    .Buff_PC(buff_pc),
    .Cnt(cnt),
    .InsM(ins_m),
    .InsL(ins_l),
    .IR(ir),
    .Fetch(fetch),
    .Halted(halted),
    .StepErr(step_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [15:0] ins;
    logic        b;
    logic [2:0]  cnt;
    logic [15:0] ir;
    logic        fetch;
    logic        halted;
    logic        se;
  } vec_t;
  vec_t vq[$];

  task automatic check(input string name, input int idx, input logic [15:0] got, input logic [15:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s[%0d]: got %h want %h", name, idx, got, want);
    end
  endtask

  task automatic apply(input logic r, input logic [15:0] ins, input logic b);
    rst = r;
    ins_in = ins;
    buff_pc = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input int idx, input logic [2:0] c, input logic [15:0] i, input logic f, input logic h, input logic s);
    logic [15:0] iw;
    iw = i;
    check("cnt", idx, {13'd0, cnt}, {13'd0, c});
    check("ir", idx, ir, iw);
    check("insm", idx, {11'd0, ins_m}, {11'd0, iw[15:11]});
    check("insl", idx, {14'd0, ins_l}, {14'd0, iw[1:0]});
    check("fetch", idx, {15'd0, fetch}, {15'd0, f});
    check("halted", idx, {15'd0, halted}, {15'd0, h});
    check("steperr", idx, {15'd0, step_err}, {15'd0, s});
  endtask

  initial begin
    vq.push_back('{1'b1, 16'hFFFF, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0});
    vq.push_back('{1'b1, 16'hFFFF, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0});
    vq.push_back('{1'b0, 16'h0000, 1'b0, 3'd1, 16'h0000, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 16'hAAAA, 1'b0, 3'd2, 16'h0000, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 16'hAAAA, 1'b0, 3'd3, 16'h0000, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 16'hAAAA, 1'b1, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0});
    vq.push_back('{1'b0, 16'h0800, 1'b1, 3'd0, 16'h0800, 1'b1, 1'b0, 1'b0});
    vq.push_back('{1'b0, 16'h1000, 1'b1, 3'd0, 16'h1000, 1'b1, 1'b0, 1'b0});
    vq.push_back('{1'b0, 16'h0800, 1'b1, 3'd0, 16'h0800, 1'b1, 1'b0, 1'b0});
    vq.push_back('{1'b0, 16'h1000, 1'b1, 3'd0, 16'h1000, 1'b1, 1'b0, 1'b0});
    vq.push_back('{1'b0, 16'h1800, 1'b0, 3'd1, 16'h1800, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 16'h5555, 1'b0, 3'd2, 16'h1800, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b1, 16'h5555, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0});
    vq.push_back('{1'b0, 16'h0000, 1'b0, 3'd1, 16'h0000, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 16'h0000, 1'b0, 3'd2, 16'h0000, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 16'h0000, 1'b0, 3'd3, 16'h0000, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 16'h0000, 1'b0, 3'd4, 16'h0000, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 16'h0000, 1'b0, 3'd5, 16'h0000, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 16'h0000, 1'b0, 3'd6, 16'h0000, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 16'h0000, 1'b0, 3'd7, 16'h0000, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, WD});
    vq.push_back('{1'b0, 16'h0800, 1'b0, 3'd1, 16'h0800, 1'b0, 1'b0, WD});
    vq.push_back('{1'b0, 16'h0800, 1'b0, 3'd2, 16'h0800, 1'b0, 1'b0, WD});
    vq.push_back('{1'b1, 16'hFFFF, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < vq.size(); i++) begin
      apply(vq[i].r, vq[i].ins, vq[i].b);
      check_all(i, vq[i].cnt, vq[i].ir, vq[i].fetch, vq[i].halted, vq[i].se);
    end
    apply(1'b0, 16'h0000, 1'b0);
    for (int i = 2; i <= 7; i++) apply(1'b0, 16'h0000, 1'b0);
    check_all(100, 3'd7, 16'h0000, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 16'h0000, 1'b1);
    check_all(101, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 16'hE001, 1'b0);
    check_all(200, 3'd1, 16'hE001, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 16'h0000, 1'b0);
    check_all(201, 3'd2, 16'hE001, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 16'h0000, 1'b1);
    check_all(202, 3'd0, 16'hE001, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 16'($urandom), i[0]);
      check_all(210 + i, 3'd0, 16'hE001, 1'b0, 1'b1, 1'b0);
    end
    apply(1'b1, 16'h0800, 1'b0);
    check_all(230, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 16'h0800, 1'b0);
    check_all(231, 3'd1, 16'h0800, 1'b0, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
